// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared constants for the up/down modulo counter: direction
//                encoding of the 'up' input and the wrap/saturate mode
//                encoding of the SATURATE parameter.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Direction encoding, as seen on the 'up' input
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // Boundary behaviour, as selected by the SATURATE parameter
    localparam bit   MODE_WRAP = 1'b0;
    localparam bit   MODE_SAT  = 1'b1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : prescaler
//  Description : Counts enabled cycles 0..PRESCALE-1. The strobe is high
//                combinationally on the enabled cycle in which the counter
//                sits at PRESCALE-1; the counter returns to 0 on that edge.
//                With PRESCALE=1 the strobe is simply 'en'.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous active-high reset (counter to 0)
//                clear  - synchronous clear (counter to 0), below reset
//                en     - count enable; counter holds when low
//                strobe - step strobe for the parent counter
//  Revision    : 1.0 - initial release
// ============================================================================
module prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic strobe
);

    // One extra state of headroom keeps the width at least 1 for PRESCALE=1
    localparam int unsigned       c_CW   = $clog2(PRESCALE + 1);
    localparam logic [c_CW-1:0]   c_TERM = c_CW'(PRESCALE - 1);

    logic [c_CW-1:0] cnt_q;
    logic [c_CW-1:0] cnt_d;
    logic            w_at_term;

    assign w_at_term = (cnt_q == c_TERM);
    assign strobe    = en & w_at_term;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = w_at_term ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : prescaler
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_mod_counter
//  Description : Up/down counter over 0..MAX_VALUE with optional prescaler,
//                synchronous load (clamped to MAX_VALUE), wrap or saturate
//                boundary behaviour and a registered terminal-count pulse.
//                Per-edge priority: reset, load, step.
//  Ports       : clk        - rising-edge clock
//                reset      - synchronous active-high reset
//                en         - count enable
//                up         - direction (DIR_UP / DIR_DOWN)
//                load       - synchronous load request
//                load_value - value to load (clamped to MAX_VALUE)
//                count      - registered count
//                tc         - registered one-cycle terminal-count pulse
//                zero       - count == 0, decoded from the count register
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  MAX_VALUE = {WIDTH{1'b1}},
    parameter bit                SATURATE  = MODE_WRAP,
    parameter int unsigned       PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;

    logic             w_strobe;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_boundary;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_load_val;

    // ------------------------------------------------------------------
    // Prescaler: a load restarts the prescale period so the first step
    // after a load always needs a full PRESCALE enabled cycles.
    // ------------------------------------------------------------------
    prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (load),
        .en     (en),
        .strobe (w_strobe)
    );

    assign w_at_max   = (count_q == MAX_VALUE);
    assign w_at_zero  = (count_q == '0);
    assign w_boundary = (up == DIR_UP) ? w_at_max : w_at_zero;

    // Clamp keeps count within 0..MAX_VALUE regardless of the loaded value
    assign w_load_val = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;

    // The +1 / -1 paths are only taken away from the boundary, so neither
    // can overflow WIDTH bits.
    always_comb begin
        w_step_val = count_q;
        if (up == DIR_UP) begin
            if (w_at_max) begin
                w_step_val = (SATURATE == MODE_SAT) ? MAX_VALUE : '0;
            end else begin
                w_step_val = count_q + 1'b1;
            end
        end else begin
            if (w_at_zero) begin
                w_step_val = (SATURATE == MODE_SAT) ? '0 : MAX_VALUE;
            end else begin
                w_step_val = count_q - 1'b1;
            end
        end
    end

    // tc flags any step taken at the boundary, including repeated
    // saturated steps that leave count unchanged.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = w_load_val;
        end else if (w_strobe) begin
            count_d = w_step_val;
            tc_d    = w_boundary;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign zero  = (count_q == '0);

endmodule : updown_mod_counter
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_mod_counter
//  Description : Scoreboard bench for updown_mod_counter. Three instances:
//                0 = WIDTH 4, MAX 9, wrap,     PRESCALE 1
//                1 = WIDTH 4, MAX 9, saturate, PRESCALE 1
//                2 = WIDTH 4, MAX 9, wrap,     PRESCALE 3
//                The driver applies one cycle of inputs and pushes the
//                hand-computed post-edge state; the monitor pops and compares
//                on the following falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;

    typedef struct {
        int         dut;
        logic [3:0] cnt;
        logic       tc;
        string      name;
    } exp_t;

    exp_t q[$];

    logic       clk = 1'b0;
    logic       rst  [3];
    logic       en   [3];
    logic       up   [3];
    logic       load [3];
    logic [3:0] lv   [3];
    logic [3:0] cnt  [3];
    logic       tc   [3];
    logic       zero [3];

    int checks = 0;
    int passed = 0;
    bit drv_done = 1'b0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
        .clk(clk), .reset(rst[0]), .en(en[0]), .up(up[0]), .load(load[0]),
        .load_value(lv[0]), .count(cnt[0]), .tc(tc[0]), .zero(zero[0]));

    updown_mod_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
        .clk(clk), .reset(rst[1]), .en(en[1]), .up(up[1]), .load(load[1]),
        .load_value(lv[1]), .count(cnt[1]), .tc(tc[1]), .zero(zero[1]));

    updown_mod_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b0), .PRESCALE(3)) u_pre (
        .clk(clk), .reset(rst[2]), .en(en[2]), .up(up[2]), .load(load[2]),
        .load_value(lv[2]), .count(cnt[2]), .tc(tc[2]), .zero(zero[2]));

    // One cycle of stimulus on one instance, then queue the expected result
    task automatic cyc(input int d, input bit r, input bit e, input bit u,
                       input bit l, input logic [3:0] v,
                       input logic [3:0] ec, input bit et, input string nm);
        exp_t x;
        rst[d] = r; en[d] = e; up[d] = u; load[d] = l; lv[d] = v;
        @(posedge clk);
        #1;
        x.dut = d; x.cnt = ec; x.tc = et; x.name = nm;
        q.push_back(x);
    endtask

    // Monitor: compares count, tc and zero against the queued expectation
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t x;
            logic [5:0] act;
            logic [5:0] req;
            x   = q.pop_front();
            act = {cnt[x.dut], tc[x.dut], zero[x.dut]};
            req = {x.cnt, x.tc, (x.cnt == 4'd0)};
            checks++;
            if (act === req) begin
                passed++;
            end else begin
                $display("FAIL %s (dut%0d): got count=%0d tc=%0b zero=%0b, expected count=%0d tc=%0b zero=%0b",
                         x.name, x.dut, act[5:2], act[1], act[0], req[5:2], req[1], req[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; up[i] = 1'b1; load[i] = 1'b0; lv[i] = 4'd0;
        end
        @(posedge clk);
        #1;

        // ---------------- instance 0: wrap, PRESCALE 1 ----------------
        cyc(0, 1, 1, 1, 1, 4'd5, 4'd0, 0, "reset_over_load_en");
        for (int i = 1; i <= 9; i++) cyc(0, 0, 1, 1, 0, 4'd0, 4'(i), 0, "up_count");
        cyc(0, 0, 1, 1, 0, 4'd0, 4'd0, 1, "up_wrap_tc");
        cyc(0, 0, 1, 1, 0, 4'd0, 4'd1, 0, "up_after_wrap");
        cyc(0, 0, 1, 0, 1, 4'd0, 4'd0, 0, "load_zero");
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd9, 1, "down_wrap_tc");
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd8, 0, "down_8");
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd7, 0, "down_7");
        cyc(0, 0, 1, 1, 0, 4'd0, 4'd8, 0, "dir_change_up");
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd7, 0, "dir_change_down");
        cyc(0, 0, 0, 1, 0, 4'd0, 4'd7, 0, "en_low_hold");
        cyc(0, 0, 1, 1, 1, 4'd12, 4'd9, 0, "load12_clamp_over_step");
        cyc(0, 0, 1, 1, 1, 4'd12, 4'd9, 0, "load_at_boundary_no_tc");
        cyc(0, 0, 1, 1, 0, 4'd0, 4'd0, 1, "wrap_after_load");
        cyc(0, 0, 0, 1, 1, 4'd15, 4'd9, 0, "load15_clamp");
        cyc(0, 0, 0, 1, 1, 4'd3, 4'd3, 0, "load3");

        // ---------------- instance 1: saturate, PRESCALE 1 -------------
        cyc(1, 1, 0, 1, 0, 4'd0, 4'd0, 0, "sat_reset");
        cyc(1, 0, 1, 0, 0, 4'd0, 4'd0, 1, "sat_down_at_zero_1");
        cyc(1, 0, 1, 0, 0, 4'd0, 4'd0, 1, "sat_down_at_zero_2");
        cyc(1, 0, 1, 1, 1, 4'd8, 4'd8, 0, "sat_load8");
        cyc(1, 0, 1, 1, 0, 4'd0, 4'd9, 0, "sat_up_to_9");
        cyc(1, 0, 1, 1, 0, 4'd0, 4'd9, 1, "sat_hold_1");
        cyc(1, 0, 1, 1, 0, 4'd0, 4'd9, 1, "sat_hold_2");
        cyc(1, 0, 1, 1, 0, 4'd0, 4'd9, 1, "sat_hold_3");
        cyc(1, 0, 1, 0, 0, 4'd0, 4'd8, 0, "sat_down_from_9");

        // ---------------- instance 2: wrap, PRESCALE 3 -----------------
        cyc(2, 1, 1, 1, 0, 4'd0, 4'd0, 0, "pre_reset");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd0, 0, "pre_en1");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd0, 0, "pre_en2");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd1, 0, "pre_en3_step");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd1, 0, "pre_en4");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd1, 0, "pre_en5");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd2, 0, "pre_en6_step");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd2, 0, "toggle_en1");
        cyc(2, 0, 0, 1, 0, 4'd0, 4'd2, 0, "toggle_en0");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd2, 0, "toggle_en2");
        cyc(2, 0, 0, 1, 0, 4'd0, 4'd2, 0, "toggle_en0b");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd3, 0, "toggle_en3_step");
        cyc(2, 0, 0, 1, 1, 4'd5, 4'd5, 0, "pre_load5");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd5, 0, "mid_prescale_1");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd5, 0, "mid_prescale_2");
        cyc(2, 1, 1, 1, 0, 4'd0, 4'd0, 0, "reset_mid_prescale");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd0, 0, "post_reset_en1");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd0, 0, "post_reset_en2");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd1, 0, "post_reset_en3_step");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd1, 0, "pre_part_1");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd1, 0, "pre_part_2");
        cyc(2, 0, 1, 1, 1, 4'd4, 4'd4, 0, "load_clears_prescale");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd4, 0, "post_load_en1");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd4, 0, "post_load_en2");
        cyc(2, 0, 1, 1, 0, 4'd0, 4'd5, 0, "post_load_en3_step");
        cyc(2, 0, 0, 0, 1, 4'd0, 4'd0, 0, "pre_load0");
        cyc(2, 0, 1, 0, 0, 4'd0, 4'd0, 0, "pre_down_en1");
        cyc(2, 0, 1, 0, 0, 4'd0, 4'd0, 0, "pre_down_en2");
        cyc(2, 0, 1, 0, 0, 4'd0, 4'd9, 1, "pre_down_wrap_tc");
        cyc(2, 0, 0, 0, 0, 4'd0, 4'd9, 0, "pre_tc_one_cycle");

        drv_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (checks == 0) begin
            $display("FAIL no checks were performed");
        end
        if (passed != checks) begin
            $display("FAIL %0d of %0d checks failed", checks - passed, checks);
        end
        if (q.size() != 0) begin
            $display("FAIL %0d expectations left unchecked", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_updown_mod_counter
`default_nettype wire
